// File: rtl/ram_stream_pkg.sv
// Shared types and constants for the RAM stream reader and its output buffer.
// The buffer depth doubles as the read-credit limit.
package ram_stream_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer (output register + skid register); push to output in 1 cycle.
// Producer must respect occ_o credit: a push into a full buffer without a same-cycle pop is not allowed.
module stream_skid_buf
  import ram_stream_pkg::*;
#(
  parameter int W = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push_vld_i,
  input  logic [W-1:0]     push_dat_i,
  input  logic             pop_rdy_i,
  output logic             out_vld_o,
  output logic [W-1:0]     out_dat_o,
  output logic [OCC_W-1:0] occ_o
);

  logic         out_vld_q, out_vld_d;
  logic         skid_vld_q, skid_vld_d;
  logic [W-1:0] out_dat_q, out_dat_d;
  logic [W-1:0] skid_dat_q, skid_dat_d;
  logic         pop;

  always_comb begin
    out_vld_d  = out_vld_q;
    skid_vld_d = skid_vld_q;
    out_dat_d  = out_dat_q;
    skid_dat_d = skid_dat_q;
    pop        = out_vld_q & pop_rdy_i;

    if (pop) begin
      if (skid_vld_q) begin
        out_dat_d = skid_dat_q;
        if (push_vld_i) begin
          skid_dat_d = push_dat_i;
        end else begin
          skid_vld_d = 1'b0;
        end
      end else if (push_vld_i) begin
        out_dat_d = push_dat_i;
      end else begin
        out_vld_d = 1'b0;
      end
    end else if (push_vld_i) begin
      // Skid is only ever occupied while the output register is stalled.
      if (!out_vld_q) begin
        out_vld_d = 1'b1;
        out_dat_d = push_dat_i;
      end else begin
        skid_vld_d = 1'b1;
        skid_dat_d = push_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      out_dat_q  <= '0;
      skid_dat_q <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      out_dat_q  <= out_dat_d;
      skid_dat_q <= skid_dat_d;
    end
  end

  assign out_vld_o = out_vld_q;
  assign out_dat_o = out_dat_q;
  assign occ_o     = OCC_W'(out_vld_q) + OCC_W'(skid_vld_q);

endmodule

// File: rtl/ram_stream_reader.sv
// Sweeps a wrapping RAM address range and streams the words out; first beat 3 cycles after start.
// Reads are credit-limited so in-flight plus buffered words never exceed the 2-entry buffer.
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  output logic                  m_last,
  input  logic                  m_ready
);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issued_q, issued_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [OCC_W-1:0]      occ;
  logic [OCC_W-1:0]      occ_after;
  logic [2:0]            used;
  logic                  pop;
  logic                  issue;
  logic                  issue_is_last;
  logic [DATA_WIDTH:0]   buf_dat;

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    len_d           = len_q;
    issued_d        = issued_q;

    pop             = m_valid & m_ready;
    // A word popped this cycle frees its slot for a read issued this cycle.
    used            = 3'(inflight_q) + 3'(occ) - 3'(pop);
    occ_after       = occ - OCC_W'(pop);
    issue           = (state_q == RUN) && (issued_q < len_q) && (used < 3'(BUF_DEPTH));
    issue_is_last   = issue && ((issued_q + (ADDR_WIDTH+1)'(1)) == len_q);
    inflight_d      = issue;
    inflight_last_d = issue_is_last;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d   = base_addr;
          len_d    = length;
          issued_d = '0;
          state_d  = (length == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (issue) begin
          addr_d   = addr_q + ADDR_WIDTH'(1);
          issued_d = issued_q + (ADDR_WIDTH+1)'(1);
          if (issue_is_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!inflight_q && (occ_after == '0)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      len_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      len_q           <= len_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // ram_q is only meaningful the cycle after an issue; inflight_q gates the capture.
  stream_skid_buf #(
    .W (DATA_WIDTH + 1)
  ) u_skid (
    .clk        (clk),
    .resetn     (resetn),
    .push_vld_i (inflight_q),
    .push_dat_i ({inflight_last_q, ram_q}),
    .pop_rdy_i  (m_ready),
    .out_vld_o  (m_valid),
    .out_dat_o  (buf_dat),
    .occ_o      (occ)
  );

  assign m_data        = buf_dat[DATA_WIDTH-1:0];
  assign m_last        = buf_dat[DATA_WIDTH];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign ram_read_addr = addr_q;

endmodule

// File: tb/tb_ram_stream_reader.sv
// Bench for ram_stream_reader: behavioural RAM holding word i = i, scoreboard of expected beats,
// table of commands plus hand-written reset and mid-command reset sequences.
module tb_ram_stream_reader;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetn;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_q;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_last;
  logic          m_ready;

  logic [DW-1:0] mem [DEPTH];

  typedef struct {
    logic [DW-1:0] d;
    logic          l;
  } exp_t;

  typedef struct {
    int base;
    int len;
    int mode;       // 0: ready high, 1: random ready, 2: ready low until cycle 14
    int noise;      // extra start pulses while busy
    int exp_first;  // first m_valid cycle, -1 = never
    int exp_done;   // done cycle, -1 = don't care
  } vec_t;

  exp_t sb[$];
  vec_t vecs[8];
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) ram_q <= mem[ram_read_addr];

  ram_stream_reader #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .base_addr     (base_addr),
    .length        (length),
    .busy          (busy),
    .done          (done),
    .ram_read_addr (ram_read_addr),
    .ram_q         (ram_q),
    .m_data        (m_data),
    .m_valid       (m_valid),
    .m_last        (m_last),
    .m_ready       (m_ready)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run_cmd(input int b, input int l, input int mode, input int noise,
                         output int first_v, output int done_c, output int beats);
    exp_t          e;
    bit            hold;
    logic [DW-1:0] hd;
    logic          hl;
    for (int i = 0; i < l; i++) begin
      e.d = DW'((b + i) % DEPTH);
      e.l = (i == l - 1);
      sb.push_back(e);
    end
    first_v = -1;
    done_c  = -1;
    beats   = 0;
    hold    = 1'b0;
    hd      = '0;
    hl      = 1'b0;
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(b);
    length    = (AW+1)'(l);
    @(posedge clk); #1;
    for (int cyc = 1; cyc < 400 && done_c < 0; cyc++) begin
      base_addr = AW'($urandom);
      length    = (AW+1)'($urandom);
      start     = (noise != 0 && cyc >= 2) ? 1'($urandom) : 1'b0;
      case (mode)
        1:       m_ready = 1'($urandom);
        2:       m_ready = (cyc >= 14);
        default: m_ready = 1'b1;
      endcase
      @(negedge clk);
      chk("busy_during_cmd", int'(busy), 1);
      if (cyc == 1 && l > 0) chk("first_read_addr", int'(ram_read_addr), b);
      if (hold) begin
        chk("hold_valid", int'(m_valid), 1);
        chk("hold_data", int'(m_data), int'(hd));
        chk("hold_last", int'(m_last), int'(hl));
      end
      if (mode == 2 && cyc == 13) begin
        chk("stall_valid", int'(m_valid), 1);
        chk("stall_data", int'(m_data), 0);
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        beats++;
        chk("beat_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("data", int'(m_data), int'(e.d));
          chk("last", int'(m_last), int'(e.l));
        end
      end
      hold = m_valid && !m_ready;
      hd   = m_data;
      hl   = m_last;
      if (done) done_c = cyc;
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("done_seen", int'(done_c >= 0), 1);
    chk("busy_after_done", int'(busy), 0);
    chk("beat_count", beats, l);
    chk("scoreboard_empty", sb.size(), 0);
    sb.delete();
  endtask

  initial begin
    int first_v, done_c, beats;

    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    vecs[0] = '{base: 5,  len: 4,  mode: 0, noise: 0, exp_first: 3,  exp_done: 7};
    vecs[1] = '{base: 62, len: 4,  mode: 0, noise: 0, exp_first: 3,  exp_done: 7};
    vecs[2] = '{base: 0,  len: 64, mode: 1, noise: 0, exp_first: -1, exp_done: -1};
    vecs[3] = '{base: 0,  len: 8,  mode: 2, noise: 0, exp_first: 3,  exp_done: 22};
    vecs[4] = '{base: 9,  len: 0,  mode: 0, noise: 0, exp_first: -1, exp_done: 1};
    vecs[5] = '{base: 30, len: 6,  mode: 0, noise: 1, exp_first: 3,  exp_done: 9};
    vecs[6] = '{base: 63, len: 1,  mode: 0, noise: 0, exp_first: 3,  exp_done: 4};
    vecs[7] = '{base: 17, len: 64, mode: 0, noise: 1, exp_first: 3,  exp_done: 67};

    resetn    = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    length    = '0;
    m_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_valid", int'(m_valid), 0);
    chk("rst_last", int'(m_last), 0);
    chk("rst_data", int'(m_data), 0);
    chk("rst_addr", int'(ram_read_addr), 0);
    resetn = 1'b1;

    for (int v = 0; v < 8; v++) begin
      run_cmd(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].noise, first_v, done_c, beats);
      if (vecs[v].mode != 1) chk($sformatf("v%0d_first_valid", v), first_v, vecs[v].exp_first);
      if (vecs[v].exp_done >= 0) chk($sformatf("v%0d_done_cycle", v), done_c, vecs[v].exp_done);
    end

    // Reset in cycle 5 of a 16-word command aborts it with no done and no further beats.
    @(posedge clk); #1;
    start     = 1'b1;
    base_addr = AW'(8);
    length    = (AW+1)'(16);
    m_ready   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("abort_valid", int'(m_valid), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    resetn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("abort_quiet", int'(done | m_valid | busy), 0);
      @(posedge clk); #1;
    end
    run_cmd(20, 3, 0, 0, first_v, done_c, beats);
    chk("after_abort_first_valid", first_v, 3);
    chk("after_abort_done_cycle", done_c, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
